multiport_reg_file: RTL and testbench

Parametrised general-purpose register file for the single-cycle MIPS datapath and its successors. Provides configurable data width, depth and read-port count, one write port, a hardware clear sweep after reset or on request, and a per-register busy scoreboard for multi-cycle and pipelined producers. It sits between decode (read addresses), writeback (write port) and the issue logic (scoreboard).

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/multiport_reg_file_if.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/multiport_reg_file.sv | 114 +++++++++++
 tb/tb_multiport_reg_file.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for multiport_reg_file.
//   rf_state_e  : sweep/operation state (RF_CLEAR, RF_READY)
//   RF_DATA_W   : default register width
//   RF_DEPTH    : default register count
//   rd_lsb()    : LSB of read port i inside a packed per-port bus
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_DEPTH  = 32;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Port i occupies [i*width +: width] of a packed multi-port bus.
  function automatic int unsigned rd_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/multiport_reg_file_if.sv
// Register-file bus: read ports, write port, issue (scoreboard set) port and status.
//   clear_req  : restart the clear sweep
//   ready      : sweep done, file accepts writes
//   rd_addr    : NUM_RD packed read addresses
//   rd_data    : NUM_RD packed read data (combinational)
//   rd_busy    : scoreboard bit per read address
//   wr_en/wr_addr/wr_data : write port
//   issue_en/issue_addr   : mark a register busy
//   busy       : full scoreboard vector
// master = requester (decode/writeback/issue), slave = register file.
interface multiport_reg_file_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                       clear_req;
  logic                       ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       issue_en;
  logic [ADDR_W-1:0]          issue_addr;
  logic [DEPTH-1:0]           busy;

  modport master (
    output clear_req, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  ready, rd_data, rd_busy, busy
  );

  modport slave (
    input  clear_req, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output ready, rd_data, rd_busy, busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. Priority: flush > set (issue) > clear (write).
//   clock, reset : clock, async active-high reset (clears all busy bits)
//   flush_i      : clear every busy bit on the next edge
//   set_en_i/set_addr_i : mark a register busy
//   clr_en_i/clr_addr_i : mark a register no longer busy
//   rd_addr_i    : packed read addresses for the per-port lookup
//   busy_o       : full busy vector
//   rd_busy_o    : busy bit of each read address
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     set_en_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [DEPTH-1:0]         busy_o,
  output logic [NUM_RD-1:0]        rd_busy_o
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    if (flush_i)  busy_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
    assign rd_busy_o[i] = busy_q[rd_addr_i[rd_lsb(i, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/multiport_reg_file.sv
// Multi-read, single-write register file with a hardware clear sweep and busy scoreboard.
//   clock : single clock, rising edge
//   reset : async active-high; enters the clear sweep, flushes the scoreboard
//   bus   : multiport_reg_file_if.slave (read/write/issue ports and status)
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
// Storage is not reset; the sweep writes zero to every entry before ready rises.
module multiport_reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic                  clock,
  input logic                  reset,
  multiport_reg_file_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              sweep_we;
  logic              ready;
  logic              user_we;
  logic              issue_ok;
  logic [NUM_RD-1:0] sb_rd_busy;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign ready = (state_q == RF_READY);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    if (bus.clear_req) begin
      state_d = RF_CLEAR;
      ptr_d   = '0;
    end else if (state_q == RF_CLEAR) begin
      sweep_we = 1'b1;
      ptr_d    = ptr_q + 1'b1;
      if (ptr_q == LastAddr) state_d = RF_READY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Writes and issues only land in READY and are discarded by a same-cycle clear_req.
  assign user_we  = ready && bus.wr_en && !bus.clear_req &&
                    !(ZERO_REG && bus.wr_addr == '0);
  assign issue_ok = ready && bus.issue_en && !(ZERO_REG && bus.issue_addr == '0);

  always_ff @(posedge clock) begin
    if (sweep_we)     mem_q[ptr_q]       <= '0;
    else if (user_we) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (bus.clear_req),
    .set_en_i   (issue_ok),
    .set_addr_i (bus.issue_addr),
    .clr_en_i   (ready && bus.wr_en),
    .clr_addr_i (bus.wr_addr),
    .rd_addr_i  (bus.rd_addr),
    .busy_o     (bus.busy),
    .rd_busy_o  (sb_rd_busy)
  );

  assign bus.ready = ready;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy_bit;

    assign addr = bus.rd_addr[rd_lsb(i, ADDR_W) +: ADDR_W];

    always_comb begin
      data     = mem_q[addr];
      busy_bit = sb_rd_busy[i];
`ifdef REGFILE_BYPASS_EN
      if (ready && bus.wr_en && bus.wr_addr == addr) begin
        data     = bus.wr_data;
        busy_bit = issue_ok && bus.issue_addr == addr;
      end
`endif
      // Sweep and hard-wired zero register override everything, bypass included.
      if (!ready || (ZERO_REG && addr == '0)) begin
        data     = '0;
        busy_bit = 1'b0;
      end
    end

    assign bus.rd_data[rd_lsb(i, DATA_W) +: DATA_W] = data;
    assign bus.rd_busy[i] = busy_bit;
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
module tb_multiport_reg_file;
  import regfile_pkg::*;

  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multiport_reg_file_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus ();

  multiport_reg_file #(
    .DATA_W   (32),
    .DEPTH    (32),
    .NUM_RD   (2),
    .ZERO_REG (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep countdown, flat memory image, busy bit per register.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_busy;
  int          m_left;

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
    m_busy = '0;
    m_left = DEPTH;
  endtask

  task automatic model_step();
    if (bus.clear_req) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (bus.wr_en && bus.wr_addr != 5'd0) m_mem[bus.wr_addr] = bus.wr_data;
      if (bus.wr_en) m_busy[bus.wr_addr] = 1'b0;
      if (bus.issue_en && bus.issue_addr != 5'd0) m_busy[bus.issue_addr] = 1'b1;
    end
  endtask

  task automatic check_port(input int p, input logic [4:0] a, input logic [31:0] d,
                            input logic b);
    logic [31:0] ed;
    logic        eb;
    ed = m_mem[a];
    eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) begin
      ed = bus.wr_data;
      eb = bus.issue_en && bus.issue_addr == a;
    end
`endif
    if (m_left != 0 || a == 5'd0) begin
      ed = '0;
      eb = 1'b0;
    end
    chk($sformatf("rd_data%0d", p), 64'(d), 64'(ed));
    chk($sformatf("rd_busy%0d", p), 64'(b), 64'(eb));
  endtask

  initial begin : compare
    model_reset();
    forever begin
      @(negedge clock);
      if (reset) model_reset();
      chk("ready", 64'(bus.ready), 64'(m_left == 0));
      chk("busy", 64'(bus.busy), 64'(m_busy));
      check_port(0, bus.rd_addr[4:0], bus.rd_data[31:0],  bus.rd_busy[0]);
      check_port(1, bus.rd_addr[9:5], bus.rd_data[63:32], bus.rd_busy[1]);
      if (!reset) model_step();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.issue_en  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  // Count sweep edges and pin the exact cycle ready rises.
  task automatic sweep(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (k == DEPTH - 1) chk({tag, "_ready_pre"}, 64'(bus.ready), 64'd0);
      if (k == DEPTH)     chk({tag, "_ready_at"},  64'(bus.ready), 64'd1);
    end
  endtask

  logic [31:0] old_r3;

  initial begin : stim
    idle();
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.issue_addr = '0;
    rd(5'd0, 5'd0);
    repeat (3) tick();
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_busy",  64'(bus.busy),  64'd0);
    reset = 1'b0;

    // Sweep after reset; a write to r5 mid-sweep must be lost.
    rd(5'd5, 5'd7);
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 10) wr(5'd5, 32'h0000DEAD);
      else         bus.wr_en = 1'b0;
      tick();
      if (k == DEPTH - 1) chk("init_ready_pre", 64'(bus.ready), 64'd0);
      if (k == DEPTH)     chk("init_ready_at",  64'(bus.ready), 64'd1);
    end
    idle();
    #1 chk("r5_after_sweep", 64'(bus.rd_data[31:0]), 64'd0);

    // Plain writes, visible the next cycle; r0 stays zero.
    wr(5'd7, 32'h7F7FFFFF);
    tick();
    wr(5'd8, 32'h7F400001);
    rd(5'd7, 5'd8);
    tick();
    idle();
    #1;
    chk("r7", 64'(bus.rd_data[31:0]),  64'h7F7FFFFF);
    chk("r8", 64'(bus.rd_data[63:32]), 64'h7F400001);
    wr(5'd0, 32'h00001234);
    tick();
    idle();
    rd(5'd0, 5'd7);
    #1 chk("r0_zero", 64'(bus.rd_data[31:0]), 64'd0);

    // Read-during-write on r3.
    wr(5'd3, 32'h11111111);
    tick();
    old_r3 = 32'h11111111;
    wr(5'd3, 32'hAAAA5555);
    rd(5'd3, 5'd8);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("r3_rdw", 64'(bus.rd_data[31:0]), 64'hAAAA5555);
`else
    chk("r3_rdw", 64'(bus.rd_data[31:0]), 64'(old_r3));
`endif
    tick();
    idle();
    #1 chk("r3_after", 64'(bus.rd_data[31:0]), 64'hAAAA5555);

    // Issue r4, write it two cycles later.
    bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
    tick();
    idle();
    chk("busy4_c1", 64'(bus.busy[4]), 64'd1);
    tick();
    chk("busy4_c2", 64'(bus.busy[4]), 64'd1);
    wr(5'd4, 32'd21);
    tick();
    idle();
    chk("busy4_clr", 64'(bus.busy[4]), 64'd0);
    wr(5'd9, 32'h99);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
    tick();
    idle();
    chk("busy9_issue_wins", 64'(bus.busy[9]), 64'd1);

    // clear_req with r4 busy and holding 21.
    bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
    rd(5'd4, 5'd9);
    tick();
    idle();
    #1;
    chk("r4_21", 64'(bus.rd_data[31:0]), 64'd21);
    chk("r4_busy_port", 64'(bus.rd_busy[0]), 64'd1);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk("clr_busy", 64'(bus.busy), 64'd0);
    chk("clr_ready", 64'(bus.ready), 64'd0);
    sweep("clr");
    #1 chk("r4_cleared", 64'(bus.rd_data[31:0]), 64'd0);

    // Reset at sweep pointer 17.
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    #1 chk("midsweep_ready", 64'(bus.ready), 64'd0);
    tick();
    reset = 1'b0;
    sweep("rst");

    // Randomised traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      bus.wr_en      = 1'($urandom_range(0, 1));
      bus.wr_addr    = 5'($urandom_range(0, 31));
      bus.wr_data    = $urandom;
      bus.issue_en   = ($urandom_range(0, 3) == 0);
      bus.issue_addr = 5'($urandom_range(0, 31));
      bus.clear_req  = ($urandom_range(0, 299) == 0);
      rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) bus.rd_addr[4:0] = bus.wr_addr;
      if ($urandom_range(0, 3) == 0) bus.rd_addr[9:5] = bus.issue_addr;
      tick();
    end
    idle();
    repeat (DEPTH + 1) tick();

    // Asynchronous reset mid-operation with a busy bit set.
    bus.issue_en = 1'b1; bus.issue_addr = 5'd6;
    tick();
    idle();
    chk("busy6_set", 64'(bus.busy[6]), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_ready", 64'(bus.ready), 64'd0);
    tick();
    reset = 1'b0;
    sweep("final");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
